// File: rtl/spike_decoder.sv
// Spike decoder: synchronises an asynchronous spike train, counts rising edges over
// back-to-back windows of WINDOW cycles and presents saturating counts on a valid/ready register.
module spike_decoder #(
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] code,
  output logic             sat,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_p;
  logic [WIN_W-1:0]       win_cnt_q;
  logic [CNT_W-1:0]       cnt_q, cnt_next;
  logic                   sat_acc_q, sat_now;
  logic                   count_en, win_end, accept;

  // Front end runs regardless of en so the edge history is always current.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], spike};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_p = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en)  state_d = S_COUNT;
      S_COUNT: if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Dropping en wins over a coincident window end: the partial window is discarded.
  always_comb begin
    count_en = 1'b0;
    win_end  = 1'b0;
    if (state_q == S_COUNT && en) begin
      count_en = 1'b1;
      win_end  = (win_cnt_q == WIN_LAST);
    end
  end

  assign sat_now  = edge_p && (cnt_q == CNT_MAX);
  assign cnt_next = (edge_p && !sat_now) ? cnt_q + CNT_W'(1) : cnt_q;
  assign accept   = valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
    end else if (!count_en || win_end) begin
      win_cnt_q <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_q + WIN_W'(1);
      cnt_q     <= cnt_next;
      sat_acc_q <= sat_acc_q | sat_now;
    end
  end

  // A load coinciding with an accept replaces the accepted result without flagging overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code    <= '0;
      sat     <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (win_end) begin
      code  <= cnt_next;
      sat   <= sat_acc_q | sat_now;
      valid <= 1'b1;
      if (accept)     overrun <= 1'b0;
      else if (valid) overrun <= 1'b1;
    end else if (accept) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Self-checking bench for spike_decoder: table-driven windows, hand-written corner sequences
// and random stimulus, all compared every cycle against a behavioural window model.
module tb_spike_decoder;

  localparam int CNT_W       = 3;
  localparam int WINDOW      = 64;
  localparam int SYNC_STAGES = 2;
  localparam int MAXV        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, spike, ready;
  logic [CNT_W-1:0] code;
  logic             sat, valid, overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_decoder #(.CNT_W(CNT_W), .WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .en(en), .spike(spike), .code(code),
    .sat(sat), .valid(valid), .ready(ready), .overrun(overrun)
  );

  // Behavioural model: sampled spike history, window position, integer counts.
  bit samp_q[$];
  bit m_counting, m_satacc, m_valid, m_ovr, m_sat;
  int m_pos, m_cnt, m_code;

  typedef struct {
    int n;      // spikes in window
    int first;  // window cycle of first rise
    bit rdy;
    int code;
    bit sat;
    bit ovr;
  } vec_t;

  vec_t tab[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    m_counting = 0; m_satacc = 0; m_valid = 0; m_ovr = 0; m_sat = 0;
    m_pos = 0; m_cnt = 0; m_code = 0;
  endtask

  // A rise sampled at edge k takes effect at edge k+SYNC_STAGES.
  task automatic model_step(input bit en_v, input bit spike_v, input bit ready_v);
    int n, total, res;
    bit e, cur, prev, over, accept, load, rsat;
    samp_q.push_back(spike_v);
    if (samp_q.size() > 16) void'(samp_q.pop_front());
    n    = samp_q.size();
    cur  = (n - 1 - SYNC_STAGES >= 0) ? samp_q[n - 1 - SYNC_STAGES] : 1'b0;
    prev = (n - 2 - SYNC_STAGES >= 0) ? samp_q[n - 2 - SYNC_STAGES] : 1'b0;
    e    = cur && !prev;
    accept = m_valid && ready_v;
    load = 0; res = 0; rsat = 0;
    if (!m_counting) begin
      if (en_v) begin
        m_counting = 1; m_pos = 0; m_cnt = 0; m_satacc = 0;
      end
    end else if (!en_v) begin
      m_counting = 0;
    end else begin
      total = m_cnt + int'(e);
      over  = total > MAXV;
      if (over) total = MAXV;
      if (m_pos == WINDOW - 1) begin
        load = 1; res = total; rsat = m_satacc | over;
        m_pos = 0; m_cnt = 0; m_satacc = 0;
      end else begin
        m_pos++; m_cnt = total; m_satacc = m_satacc | over;
      end
    end
    if (load) begin
      if (m_valid && !ready_v) m_ovr = 1;
      else if (accept)         m_ovr = 0;
      m_code = res; m_sat = rsat; m_valid = 1;
    end else if (accept) begin
      m_valid = 0; m_ovr = 0;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit en_v, input bit spike_v, input bit ready_v);
    logic [CNT_W+2:0] exp_v;
    en = en_v; spike = spike_v; ready = ready_v;
    @(posedge clk);
    model_step(en_v, spike_v, ready_v);
    @(negedge clk);
    exp_v = {m_valid, m_ovr, m_sat, m_code[CNT_W-1:0]};
    check("outputs{valid,overrun,sat,code}", {valid, overrun, sat, code}, exp_v);
  endtask

  function automatic bit spike_at(input int i, input int n, input int first);
    for (int j = 0; j < n; j++)
      if (i == first + 6 * j || i == first + 6 * j + 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_window(input int n, input int first, input bit rdy);
    for (int i = 0; i < WINDOW; i++) cycle(1'b1, spike_at(i, n, first), rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code"}, code, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    bit sp_v, en_v;
    int run_len;

    tab[0]  = '{3, 10, 1'b1, 3, 1'b0, 1'b0};
    tab[1]  = '{0, 0,  1'b1, 0, 1'b0, 1'b0};
    tab[2]  = '{10, 2, 1'b1, 7, 1'b1, 1'b0};
    tab[3]  = '{2, 20, 1'b1, 2, 1'b0, 1'b0};
    tab[4]  = '{1, 62, 1'b1, 0, 1'b0, 1'b0};  // edge lands on next window's cycle 0
    tab[5]  = '{1, 61, 1'b1, 2, 1'b0, 1'b0};  // carried edge + edge on cycle WINDOW-1
    tab[6]  = '{0, 0,  1'b1, 0, 1'b0, 1'b0};
    tab[7]  = '{7, 4,  1'b1, 7, 1'b0, 1'b0};
    tab[8]  = '{8, 4,  1'b1, 7, 1'b1, 1'b0};
    tab[9]  = '{2, 10, 1'b0, 2, 1'b0, 1'b1};
    tab[10] = '{3, 10, 1'b0, 3, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; spike = 1'b0; ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    cycle(1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 11; r++) begin
      run_window(tab[r].n, tab[r].first, tab[r].rdy);
      check($sformatf("row%0d_code", r), code, tab[r].code);
      check($sformatf("row%0d_sat", r), sat, tab[r].sat);
      check($sformatf("row%0d_valid", r), valid, 1);
      check($sformatf("row%0d_overrun", r), overrun, tab[r].ovr);
    end

    // Accept clears valid and overrun together.
    cycle(1'b1, 1'b0, 1'b1);
    check("accept_valid", valid, 0);
    check("accept_overrun", overrun, 0);

    // Abandoned window: 4 spikes then en low; nothing emitted, nothing carried over.
    for (int i = 1; i < 30; i++) cycle(1'b1, spike_at(i, 4, 5), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
    check("abandon_valid", valid, 0);
    cycle(1'b1, 1'b0, 1'b1);
    run_window(1, 10, 1'b1);
    check("fresh_code", code, 1);
    check("fresh_valid", valid, 1);

    // Asynchronous reset mid-window with 5 spikes counted and a result pending.
    run_window(3, 10, 1'b0);
    check("pre_reset_code", code, 3);
    for (int i = 0; i < 40; i++) cycle(1'b1, spike_at(i, 5, 2), 1'b0);
    #2;
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    run_window(2, 10, 1'b1);
    check("post_reset_code", code, 2);
    check("post_reset_sat", sat, 0);

    // Random traffic against the model.
    sp_v = 0; en_v = 1; run_len = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_len >= 2 && $urandom_range(0, 2) == 0) begin
        sp_v = ~sp_v;
        run_len = 0;
      end
      run_len++;
      if ($urandom_range(0, 199) == 0) en_v = ~en_v;
      cycle(en_v, sp_v, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
